// File: rtl/eaglesong_nonce_search_if.sv
// Job, digest-core and result signals of the Eaglesong nonce search block.
// slave: the search block itself; master: the job source, core and result consumer.
interface eaglesong_nonce_search_if;
    logic         job_valid;
    logic         job_ready;
    logic [223:0] job_header;
    logic [31:0]  job_nonce_start;
    logic [31:0]  job_nonce_count;
    logic [255:0] job_target;

    logic [255:0] core_input_val;
    logic [6:0]   core_input_length_bytes;
    logic         core_start_eval;
    logic [255:0] core_output_val;
    logic         core_eval_output_ready;

    logic         result_valid;
    logic         result_ack;
    logic         result_found;
    logic         result_timeout;
    logic [31:0]  result_nonce;
    logic [255:0] result_digest;
    logic         busy;

    modport slave (
        input  job_valid, job_header, job_nonce_start, job_nonce_count, job_target,
        input  core_output_val, core_eval_output_ready, result_ack,
        output job_ready, core_input_val, core_input_length_bytes, core_start_eval,
        output result_valid, result_found, result_timeout, result_nonce, result_digest, busy
    );

    modport master (
        output job_valid, job_header, job_nonce_start, job_nonce_count, job_target,
        output core_output_val, core_eval_output_ready, result_ack,
        input  job_ready, core_input_val, core_input_length_bytes, core_start_eval,
        input  result_valid, result_found, result_timeout, result_nonce, result_digest, busy
    );
endinterface

// File: rtl/eaglesong_nonce_search.sv
// Sweeps a nonce range through an external Eaglesong digest core until a digest falls below target.
// Optional core watchdog: define EAGLESONG_SEARCH_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module eaglesong_nonce_search #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                      clk,
    input logic                      rst,
    eaglesong_nonce_search_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_CHECK,
        S_REPORT
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [223:0]   header;
    logic [255:0]   target;
    logic [31:0]    nonce;
    logic [31:0]    remaining;
    logic [31:0]    last_nonce;
    logic [255:0]   digest;
    logic           found_q;
    logic           timeout_q;

    logic           digest_below;
    logic           last_in_range;
    logic           wait_expired;

    assign digest_below  = digest < target;
    assign last_in_range = remaining == 32'd1;

`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    assign wait_expired = wait_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == S_SETTLE)
            wait_cnt <= '0;
        else if (state == S_WAIT)
            wait_cnt <= wait_cnt + TW'(1);
    end
`else
    // Watchdog compiled out: WAIT holds until the core answers.
    assign wait_expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // NOTE: state_nx is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (bus.job_valid)
                          state_nx = (bus.job_nonce_count == 32'd0) ? S_REPORT : S_ISSUE;
            S_ISSUE:  state_nx = S_SETTLE;
            S_SETTLE: state_nx = S_WAIT;
            S_WAIT:   if (bus.core_eval_output_ready)
                          state_nx = S_CHECK;
                      else if (wait_expired)
                          state_nx = S_REPORT;
            S_CHECK:  state_nx = (digest_below || last_in_range) ? S_REPORT : S_ISSUE;
            S_REPORT: if (bus.result_ack)
                          state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            header     <= '0;
            target     <= '0;
            nonce      <= '0;
            remaining  <= '0;
            last_nonce <= '0;
            digest     <= '0;
            found_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.job_valid) begin
                    header    <= bus.job_header;
                    target    <= bus.job_target;
                    nonce     <= bus.job_nonce_start;
                    remaining <= bus.job_nonce_count;
                    found_q   <= 1'b0;
                    timeout_q <= 1'b0;
                end
                S_ISSUE: last_nonce <= nonce;
                S_WAIT: begin
                    if (bus.core_eval_output_ready)
                        digest <= bus.core_output_val;
                    else if (wait_expired)
                        timeout_q <= 1'b1;
                end
                // Advance only on a miss so the reported nonce is the one that hit.
                S_CHECK: begin
                    if (digest_below) begin
                        found_q <= 1'b1;
                    end else begin
                        nonce     <= nonce + 32'd1;
                        remaining <= remaining - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.job_ready               = state == S_IDLE;
    assign bus.busy                    = state != S_IDLE;
    assign bus.core_start_eval         = state == S_ISSUE;
    assign bus.core_input_val          = {header, nonce};
    assign bus.core_input_length_bytes = 7'd32;
    assign bus.result_valid            = state == S_REPORT;
    assign bus.result_found            = found_q;
    assign bus.result_timeout          = timeout_q;
    assign bus.result_nonce            = last_nonce;
    assign bus.result_digest           = digest;

endmodule

// File: tb/tb_eaglesong_nonce_search.sv
// Self-checking bench for eaglesong_nonce_search: directed vector table, corner sequences, random jobs.
// Build with EAGLESONG_SEARCH_TIMEOUT_EN defined to also exercise the core watchdog.
module tb_eaglesong_nonce_search;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eaglesong_nonce_search_if bus ();

    eaglesong_nonce_search #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural digest core: answers lat cycles after start, ready stays high until next start.
    int           core_mode = 0;
    int           core_lat  = 1;
    bit           core_mute = 1'b0;
    bit           stale_force = 1'b0;
    logic         m_ready = 1'b0;
    int           m_cnt = 0;
    logic [255:0] m_dig = '0;

    int           starts = 0;
    logic [255:0] issued_q[$];

    function automatic logic [255:0] core_digest(int mode, logic [31:0] n);
        logic [31:0] h;
        case (mode)
            0: return (n == 32'd5) ? 256'h10 : {256{1'b1}};
            1: return 256'h10;
            default: begin
                h = (n ^ 32'hA5C3_1F07) * 32'h9E37_79B1;
                h = h ^ (h >> 15);
                return {h, {7{n}}};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.core_start_eval) begin
            m_ready <= 1'b0;
            m_cnt   <= core_lat;
            m_dig   <= core_digest(core_mode, bus.core_input_val[31:0]);
            starts  <= starts + 1;
            issued_q.push_back(bus.core_input_val);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_ready <= 1'b1;
        end
    end

    assign bus.core_eval_output_ready = (m_ready & ~core_mute) | stale_force;
    assign bus.core_output_val        = stale_force ? 256'h0 : m_dig;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [223:0] hdr, input logic [31:0] st, input logic [31:0] cnt,
                             input logic [255:0] tgt);
        int cyc = 0;
        while (!bus.job_ready && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("job_ready_before_offer", bus.job_ready, 1);
        starts = 0;
        issued_q.delete();
        bus.job_header      = hdr;
        bus.job_nonce_start = st;
        bus.job_nonce_count = cnt;
        bus.job_target      = tgt;
        bus.job_valid       = 1'b1;
        @(posedge clk); #1;
        bus.job_valid       = 1'b0;
    endtask

    // lat counts clock edges from the accepting edge (inclusive) until result_valid is seen.
    task automatic wait_valid(input int cyc0, output int lat);
        int cyc = cyc0;
        while (!bus.result_valid && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        check("result_valid_within_bound", bus.result_valid, 1);
        lat = cyc;
    endtask

    task automatic ack_result(input logic f, input logic [31:0] n, input logic [255:0] d);
        repeat (2) begin @(posedge clk); #1; end
        check("valid_held", bus.result_valid, 1);
        check("found_held", bus.result_found, f);
        check("nonce_held", bus.result_nonce, n);
        check("digest_held", bus.result_digest, d);
        bus.result_ack = 1'b1;
        @(posedge clk); #1;
        bus.result_ack = 1'b0;
        check("valid_clear_after_ack", bus.result_valid, 0);
        check("ready_after_ack", bus.job_ready, 1);
    endtask

    task automatic verify_job(input string tag, input logic [223:0] hdr, input logic [31:0] st,
                              input bit exp_found, input logic [31:0] exp_nonce,
                              input logic [255:0] exp_digest, input bit chk_nd,
                              input int exp_starts, input int exp_lat, input int lat);
        check({tag, "_found"}, bus.result_found, exp_found);
        check({tag, "_timeout"}, bus.result_timeout, 0);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_starts"}, starts, exp_starts);
        if (chk_nd) begin
            check({tag, "_nonce"}, bus.result_nonce, exp_nonce);
            check({tag, "_digest"}, bus.result_digest, exp_digest);
        end
        for (int i = 0; i < issued_q.size() && i < exp_starts; i++)
            check($sformatf("%s_issued%0d", tag, i), issued_q[i], {hdr, st + 32'(i)});
        ack_result(bus.result_found, bus.result_nonce, bus.result_digest);
    endtask

    typedef struct {
        logic [31:0]  start;
        logic [31:0]  count;
        logic [255:0] target;
        int           mode;
        int           lat;
        bit           exp_found;
        logic [31:0]  exp_nonce;
        logic [255:0] exp_digest;
        bit           chk_nd;
        int           exp_starts;
        int           exp_lat;
    } vec_t;

    localparam logic [223:0] HDR = 224'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF_CAFE_F00D_1234_5678;
    localparam logic [255:0] ONES = {256{1'b1}};

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int lat;
        logic [31:0]  r_start, r_count, n, ref_nonce;
        logic [255:0] r_target, d, ref_digest;
        logic [223:0] r_hdr;
        bit           ref_found;
        int           ref_tried;

        // start  count  target  mode lat found nonce  digest  chk starts latency
        vecs[0] = '{32'd9,          32'd0,  256'h11, 0, 1, 1'b0, 32'd0,   256'h0,  1'b0, 0, 1};
        vecs[1] = '{32'd3,          32'd10, 256'h11, 0, 3, 1'b1, 32'd5,   256'h10, 1'b1, 3, 19};
        vecs[2] = '{32'd100,        32'd4,  256'h10, 1, 2, 1'b0, 32'd103, 256'h10, 1'b1, 4, 21};
        vecs[3] = '{32'hFFFF_FFFE,  32'd3,  256'h11, 0, 1, 1'b0, 32'd0,   ONES,    1'b1, 3, 13};
        vecs[4] = '{32'd5,          32'd1,  256'h10, 0, 2, 1'b0, 32'd5,   256'h10, 1'b1, 1, 6};
        vecs[5] = '{32'd5,          32'd1,  256'h11, 0, 4, 1'b1, 32'd5,   256'h10, 1'b1, 1, 8};

        bus.job_valid = 1'b0;
        bus.job_header = '0;
        bus.job_nonce_start = '0;
        bus.job_nonce_count = '0;
        bus.job_target = '0;
        bus.result_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_job_ready", bus.job_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_start_eval", bus.core_start_eval, 0);
        check("rst_len_bytes", bus.core_input_length_bytes, 32);
        check("rst_input_val", bus.core_input_val, 0);
        check("rst_result_nonce", bus.result_nonce, 0);
        check("rst_result_digest", bus.result_digest, 0);
        check("rst_found", bus.result_found, 0);
        check("rst_timeout", bus.result_timeout, 0);

        foreach (vecs[v]) begin
            core_mode = vecs[v].mode;
            core_lat  = vecs[v].lat;
            start_job(HDR, vecs[v].start, vecs[v].count, vecs[v].target);
            wait_valid(1, lat);
            verify_job($sformatf("vec%0d", v), HDR, vecs[v].start, vecs[v].exp_found, vecs[v].exp_nonce,
                       vecs[v].exp_digest, vecs[v].chk_nd, vecs[v].exp_starts, vecs[v].exp_lat, lat);
        end

        // Stale ready (with a digest that would qualify) held through ISSUE and SETTLE must be ignored.
        core_mode = 0;
        core_lat  = 3;
        start_job(HDR, 32'd7, 32'd1, 256'h11);
        stale_force = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        stale_force = 1'b0;
        wait_valid(3, lat);
        verify_job("stale", HDR, 32'd7, 1'b0, 32'd7, ONES, 1'b1, 1, 7, lat);

        // Reset while the core is still computing.
        core_lat = 30;
        start_job(HDR, 32'd1, 32'd2, 256'h11);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midwait_busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midwait_rst_job_ready", bus.job_ready, 1);
        check("midwait_rst_busy", bus.busy, 0);
        check("midwait_rst_valid", bus.result_valid, 0);
        check("midwait_rst_start_eval", bus.core_start_eval, 0);
        check("midwait_rst_input_val", bus.core_input_val, 0);
        check("midwait_rst_nonce", bus.result_nonce, 0);
        check("midwait_rst_found", bus.result_found, 0);
        repeat (40) @(posedge clk);
        #1;
        check("midwait_late_core_ignored", bus.result_valid, 0);
        check("midwait_idle_after_core", bus.job_ready, 1);

`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
        core_mute = 1'b1;
        core_lat  = 2;
        start_job(HDR, 32'd40, 32'd3, ONES);
        wait_valid(1, lat);
        // accept + ISSUE + SETTLE edges, then 16 cycles in WAIT
        check("timeout_latency", lat, 19);
        check("timeout_flag", bus.result_timeout, 1);
        check("timeout_found", bus.result_found, 0);
        check("timeout_nonce", bus.result_nonce, 40);
        check("timeout_starts", starts, 1);
        ack_result(1'b0, 32'd40, bus.result_digest);
        core_mute = 1'b0;
`endif

        // Random jobs against a plain sequential search model.
        core_mode = 2;
        for (int j = 0; j < 30; j++) begin
            r_hdr    = {7{$urandom()}};
            r_start  = (j % 5 == 0) ? 32'hFFFF_FFF8 : $urandom();
            r_count  = $urandom_range(1, 16);
            r_target = {32'($urandom_range(0, 32'h3000_0000)), {7{$urandom()}}};
            core_lat = $urandom_range(1, 6);

            ref_found  = 1'b0;
            ref_tried  = 0;
            ref_nonce  = '0;
            ref_digest = '0;
            for (int i = 0; i < int'(r_count) && !ref_found; i++) begin
                n = r_start + 32'(i);
                d = core_digest(2, n);
                ref_tried++;
                ref_nonce  = n;
                ref_digest = d;
                if (d < r_target) ref_found = 1'b1;
            end

            start_job(r_hdr, r_start, r_count, r_target);
            wait_valid(1, lat);
            verify_job($sformatf("rnd%0d", j), r_hdr, r_start, ref_found, ref_nonce, ref_digest, 1'b1,
                       ref_tried, 1 + ref_tried * (core_lat + 3), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
